sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Request-side controller that sits directly upstream of the `sram` block and drives its `din`, `addr`, `wr`, `rd` and `cs` pins.
- Converts a synchronous valid/ready request interface into correctly sequenced async SRAM strobes: setup, strobe, recover.
- Supports single writes and incrementing read bursts.
- Returns read data with a one-cycle valid pulse per beat, and signals transaction completion.

Parameters:
- DW, 8, data width; matches the SRAM data bus.
- AW, 8, address width; matches the SRAM address bus.
- WAIT_CYCLES, 1, number of clock cycles wr/rd stay asserted per beat; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  start address.
- req_wdata  in  DW  write data; ignored for reads.
- req_len  in  4  read burst length minus 1 (0..15 gives 1..16 beats); ignored for writes, which are always one beat.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid this cycle.
- rsp_data  out  DW  read beat data.
- done  out  1  one-cycle pulse in the final cycle of a transaction.
- busy  out  1  high whenever state is not IDLE.
- sram_dout  in  DW  SRAM read data.
- sram_din  out  DW  SRAM write data.
- sram_addr  out  AW  SRAM address.
- sram_wr  out  1  SRAM write strobe.
- sram_rd  out  1  SRAM read strobe.
- sram_cs  out  1  SRAM chip select.

Behaviour:
- All outputs are registered.
- Reset state, applied while rst=1:
  - state=IDLE.
  - sram_cs=0, sram_wr=0, sram_rd=0, sram_addr=0, sram_din=0.
  - rsp_valid=0, rsp_data=0, done=0, busy=0.
  - req_ready=0 during reset; req_ready=1 in the first IDLE cycle after reset deasserts.
- Handshake:
  - A request is accepted on the edge where req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE.
  - Request fields are captured at acceptance; later changes to them are ignored.
- FSM states:
  - IDLE: on accept, go to SETUP. Load addr reg = req_addr, beats remaining = req_len for reads or 0 for writes, and latch we and wdata.
  - SETUP (1 cycle): sram_cs=1, sram_addr=addr reg, sram_din=wdata (writes only; for reads sram_din holds its previous value), sram_wr=0, sram_rd=0. Go to STROBE.
  - STROBE (WAIT_CYCLES cycles): cs=1, with sram_wr=we or sram_rd=!we; address and data stable. For reads, rsp_data captures sram_dout on the edge that ends the last STROBE cycle. Go to RECOVER.
  - RECOVER (1 cycle): strobes=0, cs=1. For reads, rsp_valid=1. If beats remain: decrement the count, addr reg = addr reg+1 (modulo 2^AW, so 8'hFF wraps to 8'h00), go to SETUP, and keep cs=1 across the burst. Otherwise done=1 and go to IDLE with cs=0.
- Latency (accept edge at cycle T, WAIT_CYCLES=W):
  - SETUP is cycle T+1.
  - STROBE occupies cycles T+2..T+1+W.
  - RECOVER is cycle T+2+W; rsp_valid and done appear there.
  - req_ready returns high at T+3+W.
  - Each additional burst beat adds 2+W cycles.
- Strobe exclusivity: wr and rd are never high together, and neither is ever high while cs=0.
- Reset mid-transaction: on the next edge, all outputs take their reset values and the burst is abandoned. No rsp_valid or done is produced for the abandoned transaction.
- req_valid held high while busy has no effect; it is accepted at the next IDLE cycle.

Optional Feature:
- Macro: SRAM_CTRL_PERF_EN.
- When defined:
  - Adds output port perf_beats [15:0], counting completed beats (each RECOVER cycle).
  - The counter saturates at 16'hFFFF.
  - rst clears it to 0.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan (WAIT_CYCLES=1 unless stated; sram behavioural model attached):
- Write 8'hB5 to addr 8'h03, accepted at T:
  - sram_cs=1 for T+1..T+3, sram_wr=1 only at T+2, sram_addr=8'h03, sram_din=8'hB5.
  - done=1 at T+3; req_ready=0 for T+1..T+3 and 1 at T+4.
- Read addr 8'h03 after that write, accepted at T:
  - sram_rd=1 only at T+2.
  - rsp_valid=1 and done=1 at T+3 with rsp_data=8'hB5.
- Burst read at addr 8'hFE with req_len=2 (memory preloaded FE=11, FF=22, 00=33):
  - sram_addr takes FE, FF, 00.
  - rsp_valid at T+3, T+6 and T+9 with data 11, 22, 33.
  - cs stays high T+1..T+9; done only at T+9.
- rst=1 during the second STROBE of a 4-beat read:
  - Next cycle: cs, rd, rsp_valid, done and busy are all 0.
  - No further rsp_valid; req_ready=1 on the first cycle after rst deasserts.
- WAIT_CYCLES=3, read accepted at T: sram_rd=1 for T+2..T+4; rsp_valid at T+5.
- Back-to-back single writes with req_valid held high: first accepted at T, second at T+4; no overlap of cs between transactions beyond the IDLE gap.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready request front-end for an asynchronous SRAM.
// Sequences every beat as SETUP -> STROBE (WAIT_CYCLES) -> RECOVER, supports
// single writes and incrementing read bursts, and registers every output.
// Optional build macro: SRAM_CTRL_PERF_EN adds a saturating perf_beats counter.
module sram_ctrl #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [3:0]    req_len,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          done,
  output logic          busy,
  input  logic [DW-1:0] sram_dout,
  output logic [DW-1:0] sram_din,
  output logic [AW-1:0] sram_addr,
  output logic          sram_wr,
  output logic          sram_rd,
  output logic          sram_cs
`ifdef SRAM_CTRL_PERF_EN
  ,
  output logic [15:0]   perf_beats
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RECOVER
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          we_q, we_d;
  logic [3:0]    beats_q, beats_d;
  logic [3:0]    wait_q, wait_d;
  logic          cs_q, cs_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  // State and all registered outputs; synchronous reset returns everything to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      beats_q     <= '0;
      wait_q      <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      beats_q     <= beats_d;
      wait_q      <= wait_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next state plus the output values that belong to that next state, so outputs stay registered.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    din_d       = din_q;
    we_d        = we_q;
    beats_d     = beats_q;
    wait_d      = wait_q;
    cs_d        = cs_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = S_SETUP;
          addr_d  = req_addr;
          we_d    = req_we;
          beats_d = req_we ? 4'd0 : req_len;
          if (req_we) din_d = req_wdata;
          cs_d    = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        wait_d  = WAIT_LAST;
        wr_d    = we_q;
        rd_d    = !we_q;
      end
      S_STROBE: begin
        if (wait_q == 4'd0) begin
          // Read data is sampled on the edge that closes the strobe, while rd is still high.
          state_d     = S_RECOVER;
          rsp_valid_d = !we_q;
          done_d      = (beats_q == 4'd0);
          if (!we_q) rsp_data_d = sram_dout;
        end else begin
          wait_d = wait_q - 4'd1;
          wr_d   = we_q;
          rd_d   = !we_q;
        end
      end
      S_RECOVER: begin
        if (beats_q != 4'd0) begin
          beats_d = beats_q - 4'd1;
          addr_d  = addr_q + 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
          cs_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d == S_IDLE);
  assign busy_d  = (state_d != S_IDLE);

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign sram_din  = din_q;
  assign sram_addr = addr_q;
  assign sram_wr   = wr_q;
  assign sram_rd   = rd_q;
  assign sram_cs   = cs_q;

`ifdef SRAM_CTRL_PERF_EN
  logic [15:0] perf_q;

  // Counts each RECOVER cycle as a completed beat, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (state_q == S_RECOVER && perf_q != '1) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_beats = perf_q;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: table vectors, hand-written corner sequences
// and randomized transactions against a cycle-schedule reference model.
module tb_sram_ctrl;

  localparam int W  = 1;
  localparam int W3 = 3;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with WAIT_CYCLES = 1
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic [3:0] req_len;
  logic       rsp_valid, done, busy;
  logic [7:0] rsp_data;
  logic [7:0] sram_dout, sram_din, sram_addr;
  logic       sram_wr, sram_rd, sram_cs;

  // DUT with WAIT_CYCLES = 3
  logic       m3_valid, m3_ready, m3_we;
  logic [7:0] m3_addr, m3_wdata;
  logic [3:0] m3_len;
  logic       m3_rsp_valid, m3_done, m3_busy;
  logic [7:0] m3_rsp_data;
  logic [7:0] m3_dout, m3_din, m3_saddr;
  logic       m3_wr, m3_rd, m3_cs;

`ifdef SRAM_CTRL_PERF_EN
  logic [15:0] perf_beats, perf3;
`endif

  sram_ctrl #(.DW(8), .AW(8), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .busy(busy),
    .sram_dout(sram_dout), .sram_din(sram_din), .sram_addr(sram_addr),
    .sram_wr(sram_wr), .sram_rd(sram_rd), .sram_cs(sram_cs)
`ifdef SRAM_CTRL_PERF_EN
    , .perf_beats(perf_beats)
`endif
  );

  sram_ctrl #(.DW(8), .AW(8), .WAIT_CYCLES(W3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(m3_valid), .req_ready(m3_ready), .req_we(m3_we),
    .req_addr(m3_addr), .req_wdata(m3_wdata), .req_len(m3_len),
    .rsp_valid(m3_rsp_valid), .rsp_data(m3_rsp_data), .done(m3_done), .busy(m3_busy),
    .sram_dout(m3_dout), .sram_din(m3_din), .sram_addr(m3_saddr),
    .sram_wr(m3_wr), .sram_rd(m3_rd), .sram_cs(m3_cs)
`ifdef SRAM_CTRL_PERF_EN
    , .perf_beats(perf3)
`endif
  );

  // Behavioural async SRAMs: write on clock while cs&wr, combinational read while cs&rd.
  logic [7:0] mem  [256];
  logic [7:0] mem3 [256];
  always @(posedge clk) if (sram_cs && sram_wr) mem[sram_addr] <= sram_din;
  always @(posedge clk) if (m3_cs && m3_wr) mem3[m3_saddr] <= m3_din;
  assign sram_dout = (sram_cs && sram_rd) ? mem[sram_addr] : 8'h00;
  assign m3_dout   = (m3_cs && m3_rd) ? mem3[m3_saddr] : 8'h00;

  // Reference state
  logic [7:0] ref_mem [256];
  logic [7:0] last_din;
  int         perf_exp;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one transaction on the W=1 DUT (called at a negedge) and check every cycle
  // against the schedule: beat b occupies 2+W cycles (setup, W strobes, recover).
  task automatic do_txn(input logic we, input logic [7:0] a, input logic [7:0] wd,
                        input logic [3:0] len, output logic [7:0] first_d,
                        output logic [7:0] last_d, output int ncyc);
    int guard, per, beats, total, b, p;
    logic e_strobe, e_recov, e_done, seen;
    logic [7:0] ea;
    guard = 0; per = 2 + W; seen = 1'b0;
    beats = we ? 1 : int'(len) + 1;
    total = beats * per;
    first_d = '0; last_d = '0; ncyc = 0;
    req_we = we; req_addr = a; req_wdata = wd; req_len = len; req_valid = 1'b1;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble request fields after acceptance; the DUT must have captured them.
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom); req_len = 4'($urandom);
    for (int k = 1; k <= total; k++) begin
      b = (k - 1) / per;
      p = (k - 1) % per;
      e_strobe = (p >= 1) && (p <= W);
      e_recov  = (p == per - 1);
      e_done   = e_recov && (b == beats - 1);
      ea       = a + 8'(b);
      chk("txn.cs", sram_cs, 1);
      chk("txn.wr", sram_wr, we & e_strobe);
      chk("txn.rd", sram_rd, !we & e_strobe);
      chk("txn.excl", sram_wr & sram_rd, 0);
      chk("txn.addr", sram_addr, ea);
      chk("txn.din", sram_din, we ? wd : last_din);
      chk("txn.rsp_valid", rsp_valid, !we & e_recov);
      chk("txn.done", done, e_done);
      chk("txn.ready", req_ready, 0);
      chk("txn.busy", busy, 1);
      if (!we && e_recov) chk("txn.rsp_data", rsp_data, ref_mem[ea]);
      if (rsp_valid) begin
        if (!seen) first_d = rsp_data;
        seen = 1'b1;
        last_d = rsp_data;
      end
      if (sram_wr) begin
        first_d = sram_din;
        last_d  = sram_din;
      end
      if (done) ncyc = k;
      @(negedge clk);
    end
    chk("txn.end_ready", req_ready, 1);
    chk("txn.end_busy", busy, 0);
    chk("txn.end_cs", sram_cs, 0);
    chk("txn.end_strobes", sram_wr | sram_rd, 0);
    if (we) begin
      ref_mem[a] = wd;
      last_din   = wd;
    end
    perf_exp += beats;
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] len;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f, l;
    int nc;
    last_din = 8'h00;
    perf_exp = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
    m3_valid = 1'b0; m3_we = 1'b0; m3_addr = '0; m3_wdata = '0; m3_len = '0;

    vecs[0] = '{1'b1, 8'h03, 8'hB5, 4'd0, 8'hB5, 8'hB5, 3};
    vecs[1] = '{1'b0, 8'h03, 8'h00, 4'd0, 8'hB5, 8'hB5, 3};
    vecs[2] = '{1'b1, 8'hFE, 8'h11, 4'd0, 8'h11, 8'h11, 3};
    vecs[3] = '{1'b1, 8'hFF, 8'h22, 4'd0, 8'h22, 8'h22, 3};
    vecs[4] = '{1'b1, 8'h00, 8'h33, 4'd0, 8'h33, 8'h33, 3};
    vecs[5] = '{1'b0, 8'hFE, 8'h00, 4'd2, 8'h11, 8'h33, 9};
    vecs[6] = '{1'b0, 8'hFF, 8'h00, 4'd1, 8'h22, 8'h33, 6};
    vecs[7] = '{1'b1, 8'h03, 8'h6C, 4'd5, 8'h6C, 8'h6C, 3};
    vecs[8] = '{1'b0, 8'h03, 8'h00, 4'd0, 8'h6C, 8'h6C, 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.cs", sram_cs, 0);
    chk("rst.wr", sram_wr, 0);
    chk("rst.rd", sram_rd, 0);
    chk("rst.addr", sram_addr, 0);
    chk("rst.din", sram_din, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_data", rsp_data, 0);
    chk("rst.done", done, 0);
    chk("rst.busy", busy, 0);
    chk("rst.ready", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.ready", req_ready, 1);
    chk("post_rst.busy", busy, 0);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].len, f, l, nc);
      chk($sformatf("vec%0d.first", i), f, vecs[i].exp_first);
      chk($sformatf("vec%0d.last", i), l, vecs[i].exp_last);
      chk($sformatf("vec%0d.cycles", i), nc, vecs[i].exp_cyc);
    end

    // Back-to-back writes with req_valid held high
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'h01; req_len = 4'd0;
    @(negedge clk);
    req_addr = 8'h41; req_wdata = 8'h02;
    for (int k = 1; k <= 3; k++) begin
      chk("b2b.ready_low", req_ready, 0);
      chk("b2b.addr1", sram_addr, 8'h40);
      chk("b2b.din1", sram_din, 8'h01);
      chk("b2b.cs1", sram_cs, 1);
      @(negedge clk);
    end
    chk("b2b.gap_ready", req_ready, 1);
    chk("b2b.gap_cs", sram_cs, 0);
    @(negedge clk);
    chk("b2b.cs2", sram_cs, 1);
    chk("b2b.addr2", sram_addr, 8'h41);
    chk("b2b.din2", sram_din, 8'h02);
    chk("b2b.busy2", busy, 1);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b.end_ready", req_ready, 1);
    ref_mem[8'h40] = 8'h01; ref_mem[8'h41] = 8'h02; last_din = 8'h02; perf_exp += 2;

    // Reset during the second STROBE of a 4-beat read
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFE; req_len = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid.rd_before", sram_rd, 1);
    chk("mid.addr_before", sram_addr, 8'hFF);
    rst = 1'b1;
    @(negedge clk);
    chk("mid.cs", sram_cs, 0);
    chk("mid.rd", sram_rd, 0);
    chk("mid.rsp_valid", rsp_valid, 0);
    chk("mid.done", done, 0);
    chk("mid.busy", busy, 0);
    chk("mid.din", sram_din, 0);
    chk("mid.addr", sram_addr, 0);
    rst = 1'b0;
    last_din = 8'h00;
    perf_exp = 0;
    @(negedge clk);
    chk("mid.ready_after", req_ready, 1);
    for (int k = 0; k < 8; k++) begin
      chk("mid.no_rsp", rsp_valid | done | sram_cs, 0);
      @(negedge clk);
    end

    // WAIT_CYCLES = 3: write 5A to 10, then read it back
    m3_valid = 1'b1; m3_we = 1'b1; m3_addr = 8'h10; m3_wdata = 8'h5A; m3_len = 4'd0;
    @(negedge clk);
    m3_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("w3.wr", m3_wr, (k >= 2 && k <= 4));
      chk("w3.wdone", m3_done, (k == 5));
      chk("w3.busy", m3_busy, 1);
      @(negedge clk);
    end
    chk("w3.ready", m3_ready, 1);
    m3_valid = 1'b1; m3_we = 1'b0; m3_addr = 8'h10; m3_len = 4'd0;
    @(negedge clk);
    m3_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("w3.rd", m3_rd, (k >= 2 && k <= 4));
      chk("w3.cs", m3_cs, 1);
      chk("w3.addr", m3_saddr, 8'h10);
      chk("w3.rsp_valid", m3_rsp_valid, (k == 5));
      if (k == 5) chk("w3.rsp_data", m3_rsp_data, 8'h5A);
      @(negedge clk);
    end
    chk("w3.end_ready", m3_ready, 1);

    // Fill the whole memory, then random traffic
    for (int a = 0; a < 256; a++) begin
      do_txn(1'b1, 8'(a), 8'($urandom), 4'd0, f, l, nc);
    end
    for (int i = 0; i < 60; i++) begin
      logic we;
      logic [3:0] len;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      we  = 1'($urandom_range(0, 1));
      len = 4'($urandom_range(0, 15));
      do_txn(we, 8'($urandom), 8'($urandom), len, f, l, nc);
      chk("rand.cycles", nc, (we ? 1 : int'(len) + 1) * (2 + W));
    end

`ifdef SRAM_CTRL_PERF_EN
    chk("perf.beats", perf_beats, perf_exp);
    chk("perf3.beats", perf3, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
